simple_fwd_unit: RTL and testbench
==================================

SIMPLE_FWD_UNIT -- requirements
Module: simple_fwd_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of post-decode stages tracked (legal 2..4).
REQ-002 SHALL have parameter LD_STAGE, default 2, meaning the first stage index (1..DEPTH-1) at which load data can be forwarded.
REQ-003 SHALL define derived localparam SW = clog2(DEPTH), the width of the select outputs.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port adv  input  1  pipeline advance enable for this cycle.
REQ-007 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-008 SHALL have port id_ir  input  16  instruction currently in decode.
REQ-009 SHALL have port sel1  output  SW  registered sr1 forward select (0 = register file, k = stage k).
REQ-010 SHALL have port sel2  output  SW  registered sr2 forward select, same encoding as sel1.
REQ-011 SHALL have port stall  output  1  combinational load-use interlock.

Function
REQ-012 SHALL decode a producer as ld ([15:14]=00, [7:0]=0x01), add ([15:14]=00, [4:0]=00010), mul ([15:14]=00, [4:0]=00011) or li ([15:14]=01, [10:8]=000), with the destination in [13:11].
REQ-013 SHALL treat id_ir=0x0000 as nop: it neither produces nor consumes.
REQ-014 SHALL treat every non-nop id_ir as a consumer with sources sr1=[10:8] and sr2=[7:5].
REQ-015 SHALL hold a scoreboard of DEPTH entries, each {valid, dest[2:0], is_ld}; entry 1 is the youngest.
REQ-016 SHALL shift the scoreboard on each edge with adv=1 and flush=0: entry k+1 takes entry k, and entry DEPTH is discarded.
REQ-017 SHALL load entry 1 on that shift with the decode of id_ir when stall=0, or with a bubble (valid=0) when stall=1.
REQ-018 SHALL, for each source, find the youngest matching producer: the lowest j in 1..DEPTH-1 whose entry is valid with dest equal to the source; entry DEPTH is never matched.
REQ-019 SHALL drive stall=1 whenever the youngest match for either source has is_ld=1 and j<LD_STAGE and id_ir is not nop; stall is independent of adv.
REQ-020 SHALL, on an edge with adv=1, stall=0 and flush=0, capture sel1/sel2 as j of the youngest match, or 0 when there is no match.
REQ-021 SHALL, on an edge with adv=1 and stall=1, capture sel1=sel2=0 (the bubble consumes nothing).
REQ-022 SHALL hold the scoreboard and sel1/sel2 when adv=0.
REQ-023 SHALL, on an edge with flush=1, clear all valid bits and sel1/sel2, regardless of adv; stall is therefore 0 from the next cycle unless a new match arises.
REQ-024 SHALL compare sr1 and sr2 independently, so both selects may be non-zero in the same cycle.

Reset
REQ-025 SHALL, while RSTN=0, immediately clear all scoreboard valid bits, sel1=0, sel2=0 and stall=0, including when a stall or flush is in progress.
REQ-026 SHALL resume normal operation on the first rising edge after RSTN deasserts.

Configuration
REQ-027 SHALL use macro FWD_STALL_CNT_EN to control the stall counter.
REQ-028 SHALL, when FWD_STALL_CNT_EN is defined, add output stall_cnt[15:0], reset to 0, which increments on each edge with adv=1, stall=1 and flush=0 and saturates at 0xFFFF.
REQ-029 SHALL, when FWD_STALL_CNT_EN is undefined, omit the stall_cnt port and its logic entirely.

Verification (DEPTH=3, LD_STAGE=2, adv=1 unless stated)
REQ-030 SHALL cover: id_ir 0x0A62 (add r1), then 0x21A2 (sr1=r1) -> stall=0; after the second edge, sel1=1 and sel2=0.
REQ-031 SHALL cover: 0x0A62, 0x0000, 0x2522 (sr2=r1) -> after the third edge, sel2=2 and sel1=0.
REQ-032 SHALL cover: 0x0A01 (ld r1), then 0x21A2 held -> stall=1 for exactly one cycle and a bubble enters; on the next edge sel1=2; stall_cnt=1 when FWD_STALL_CNT_EN is defined.
REQ-033 SHALL cover: 0x4807 (li r1), 0x0A62 (add r1), 0x21A2 -> sel1=1 (youngest producer wins).
REQ-034 SHALL cover: ld r1 in entry 1 with 0x21A2 in decode (stall=1), flush=1 pulsed for one edge -> next cycle stall=0, sel1=0, and all valid bits are 0.
REQ-035 SHALL cover: RSTN pulsed low mid-stall -> stall, sel1 and sel2 go to 0 asynchronously; stall_cnt=0.

Source files
------------

// File: rtl/simple_fwd_unit.sv
// rtl/simple_fwd_unit.sv - operand forward-select and load-use interlock unit
// Optional stall counter enabled by defining FWD_STALL_CNT_EN.
module simple_fwd_unit #(
   parameter int DEPTH    = 3,
   parameter int LD_STAGE = 2,
   localparam int SW      = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          adv,
   input  logic          flush,
   input  logic [15:0]   id_ir,
   output logic [SW-1:0] sel1,
   output logic [SW-1:0] sel2,
   output logic          stall
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   // Entry DEPTH is never matched and has no successor, so only 1..DEPTH-1 are held.
   logic [DEPTH-1:1]      r_vld;
   logic [DEPTH-1:1]      r_ld;
   logic [DEPTH-1:1][2:0] r_dst;
   logic [SW-1:0]         r_sel1;
   logic [SW-1:0]         r_sel2;

   logic          w_nop;
   logic          w_is_ld;
   logic          w_is_alu;
   logic          w_is_li;
   logic          w_prod;
   logic [2:0]    w_dest;
   logic [2:0]    w_sr1;
   logic [2:0]    w_sr2;
   logic [SW-1:0] w_j1;
   logic [SW-1:0] w_j2;
   logic          w_lu1;
   logic          w_lu2;

   assign w_nop    = (id_ir == 16'h0000);
   assign w_is_ld  = (id_ir[15:14] == 2'b00) && (id_ir[7:0] == 8'h01);
   assign w_is_alu = (id_ir[15:14] == 2'b00) &&
                     ((id_ir[4:0] == 5'b00010) || (id_ir[4:0] == 5'b00011));
   assign w_is_li  = (id_ir[15:14] == 2'b01) && (id_ir[10:8] == 3'b000);
   assign w_prod   = w_is_ld | w_is_alu | w_is_li;
   assign w_dest   = id_ir[13:11];
   assign w_sr1    = id_ir[10:8];
   assign w_sr2    = id_ir[7:5];

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      w_j1  = '0;
      w_j2  = '0;
      w_lu1 = 1'b0;
      w_lu2 = 1'b0;
      for (int j = DEPTH - 1; j >= 1; j--) begin
         if (r_vld[j] && (r_dst[j] == w_sr1)) begin
            w_j1  = SW'(j);
            w_lu1 = r_ld[j] && (j < LD_STAGE);
         end
         if (r_vld[j] && (r_dst[j] == w_sr2)) begin
            w_j2  = SW'(j);
            w_lu2 = r_ld[j] && (j < LD_STAGE);
         end
      end
   end

   assign stall = ~w_nop & (w_lu1 | w_lu2);
   assign sel1  = r_sel1;
   assign sel2  = r_sel2;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_vld  <= '0;
         r_ld   <= '0;
         r_dst  <= '0;
         r_sel1 <= '0;
         r_sel2 <= '0;
      end else if (flush) begin
         r_vld  <= '0;
         r_sel1 <= '0;
         r_sel2 <= '0;
      end else if (adv) begin
         for (int k = DEPTH - 1; k >= 2; k--) begin
            r_vld[k] <= r_vld[k-1];
            r_ld[k]  <= r_ld[k-1];
            r_dst[k] <= r_dst[k-1];
         end
         r_vld[1] <= ~stall & w_prod;
         r_ld[1]  <= ~stall & w_is_ld;
         r_dst[1] <= w_dest;
         r_sel1   <= stall ? '0 : w_j1;
         r_sel2   <= stall ? '0 : w_j2;
      end
   end

`ifdef FWD_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_stall_cnt <= '0;
      end else if (adv && stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_simple_fwd_unit.sv
// tb/tb_simple_fwd_unit.sv - directed and randomized bench for simple_fwd_unit
// Stall counter checks are active when FWD_STALL_CNT_EN is defined.
module tb_simple_fwd_unit;
   localparam int DEPTH    = 3;
   localparam int LD_STAGE = 2;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        adv = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] id_ir = 16'h0000;
   logic [1:0]  sel1;
   logic [1:0]  sel2;
   logic        stall;
`ifdef FWD_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   simple_fwd_unit #(.DEPTH(DEPTH), .LD_STAGE(LD_STAGE)) dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .adv   (adv),
      .flush (flush),
      .id_ir (id_ir),
      .sel1  (sel1),
      .sel2  (sel2),
      .stall (stall)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit       v;
      bit [2:0] d;
      bit       ld;
   } ent_t;

   ent_t hist[$];
   int   exp_s1;
   int   exp_s2;
   int   exp_cnt;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic ent_t decode(logic [15:0] ir);
      ent_t e;
      e.d  = ir[13:11];
      e.ld = (ir[15:14] == 2'd0) && (ir[7:0] == 8'h01);
      e.v  = e.ld ||
             ((ir[15:14] == 2'd0) && (ir[4:0] == 5'd2 || ir[4:0] == 5'd3)) ||
             ((ir[15:14] == 2'd1) && (ir[10:8] == 3'd0));
      return e;
   endfunction

   function automatic int youngest(logic [2:0] src);
      for (int j = 1; j <= DEPTH - 1; j++)
         if (hist[j-1].v && hist[j-1].d == src) return j;
      return 0;
   endfunction

   function automatic bit model_stall(logic [15:0] ir);
      int j1 = youngest(ir[10:8]);
      int j2 = youngest(ir[7:5]);
      bit s = 0;
      if (ir == 16'h0000) return 0;
      if (j1 != 0 && hist[j1-1].ld && j1 < LD_STAGE) s = 1;
      if (j2 != 0 && hist[j2-1].ld && j2 < LD_STAGE) s = 1;
      return s;
   endfunction

   task automatic model_reset();
      ent_t z = '{v: 0, d: 0, ld: 0};
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(z);
      exp_s1 = 0;
      exp_s2 = 0;
      exp_cnt = 0;
   endtask

   task automatic check_outputs(string tag);
      chk({tag, "_sel1"}, 32'(sel1), 32'(exp_s1));
      chk({tag, "_sel2"}, 32'(sel2), 32'(exp_s2));
`ifdef FWD_STALL_CNT_EN
      chk({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
`endif
   endtask

   task automatic step(string tag, logic [15:0] ir, logic a, logic f);
      bit   es;
      int   j1, j2;
      ent_t bub = '{v: 0, d: 0, ld: 0};
      @(negedge CLK);
      id_ir = ir;
      adv   = a;
      flush = f;
      #1;
      es = model_stall(ir);
      j1 = youngest(ir[10:8]);
      j2 = youngest(ir[7:5]);
      chk({tag, "_stall"}, 32'(stall), 32'(es));
      @(posedge CLK);
      if (f) begin
         foreach (hist[i]) hist[i].v = 0;
         exp_s1 = 0;
         exp_s2 = 0;
      end else if (a) begin
         hist.push_front(es ? bub : decode(ir));
         void'(hist.pop_back());
         exp_s1 = es ? 0 : j1;
         exp_s2 = es ? 0 : j2;
         if (es && exp_cnt < 16'hFFFF) exp_cnt++;
      end
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [15:0] rand_ir();
      logic [2:0] d  = 3'($urandom_range(0, 3));
      logic [2:0] s1 = 3'($urandom_range(0, 3));
      logic [2:0] s2 = 3'($urandom_range(0, 3));
      logic [7:0] imm = 8'($urandom);
      case ($urandom_range(0, 5))
         0: return {2'b00, d, s1, 8'h01};
         1: return {2'b00, d, s1, s2, 5'b00010};
         2: return {2'b00, d, s1, s2, 5'b00011};
         3: return {2'b01, d, 3'b000, imm};
         4: return 16'h0000;
         default: return {2'b10, 3'($urandom), s1, s2, 5'($urandom)};
      endcase
   endfunction

   initial begin
      RSTN = 1'b1;
      model_reset();
      #1 RSTN = 1'b0;
      #1;
      check_outputs("reset");
      chk("reset_stall", 32'(stall), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;

      step("r030a", 16'h0A62, 1, 0);
      step("r030b", 16'h21A2, 1, 0);
      chk("r030_sel1", 32'(sel1), 32'd1);
      chk("r030_sel2", 32'(sel2), 32'd0);
      step("clr1", 16'h0000, 1, 1);

      step("r031a", 16'h0A62, 1, 0);
      step("r031b", 16'h0000, 1, 0);
      step("r031c", 16'h2522, 1, 0);
      chk("r031_sel2", 32'(sel2), 32'd2);
      chk("r031_sel1", 32'(sel1), 32'd0);
      step("clr2", 16'h0000, 1, 1);

      step("r032a", 16'h0A01, 1, 0);
      step("r032b", 16'h21A2, 1, 0);
      chk("r032_bubble_sel1", 32'(sel1), 32'd0);
      step("r032c", 16'h21A2, 1, 0);
      chk("r032_sel1", 32'(sel1), 32'd2);
`ifdef FWD_STALL_CNT_EN
      chk("r032_cnt", 32'(stall_cnt), 32'd1);
`endif
      step("clr3", 16'h0000, 1, 1);

      step("r033a", 16'h4807, 1, 0);
      step("r033b", 16'h0A62, 1, 0);
      step("r033c", 16'h21A2, 1, 0);
      chk("r033_sel1", 32'(sel1), 32'd1);

      step("r034a", 16'h0A01, 1, 0);
      step("r034b", 16'h21A2, 1, 1);
      step("r034c", 16'h21A2, 1, 0);
      chk("r034_sel1", 32'(sel1), 32'd0);
      step("r034d", 16'h0000, 0, 0);

      step("r035a", 16'h0A01, 1, 0);
      @(negedge CLK);
      id_ir = 16'h21A2;
      #1;
      chk("r035_pre_stall", 32'(stall), 32'd1);
      #2 RSTN = 1'b0;
      #1;
      chk("r035_stall", 32'(stall), 32'd0);
      chk("r035_sel1", 32'(sel1), 32'd0);
      chk("r035_sel2", 32'(sel2), 32'd0);
`ifdef FWD_STALL_CNT_EN
      chk("r035_cnt", 32'(stall_cnt), 32'd0);
`endif
      model_reset();
      @(negedge CLK);
      RSTN = 1'b1;

      for (int i = 0; i < 400; i++)
         step("rand", rand_ir(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 15) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
